// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator front-end: instruction width, NOP encoding
// and the issue-FSM state type.
package accel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DRAIN
    } issue_state_e;

    // Instruction = 4b opcode, 2b flags, two address fields, one data/mask field.
    function automatic int calc_ins_width(input int depth, input int w);
        int addrW;
        int dataW;
        addrW = (depth > 2) ? depth : 2;
        dataW = ((1 << depth) > w) ? (1 << depth) : w;
        return 4 + 2 + 2 * addrW + dataW;
    endfunction

    localparam int INS_W_DEFAULT = calc_ins_width(3, 16);
    localparam logic [INS_W_DEFAULT-1:0] INS_NOP = '0;

endpackage

// File: rtl/issue_fifo.sv
// Circular entry buffer for the issue queue; owns storage, pointers, occupancy and ready.
module issue_fifo #(
    parameter int QA = 3,
    parameter int EW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [EW-1:0] wdata_i,
    output logic [EW-1:0] rdata_o,
    output logic [QA:0]   level_o,
    output logic          ready_o,
    output logic          empty_o
);

    localparam int N = 1 << QA;

    logic [EW-1:0] mem_q [N];
    logic [QA-1:0] wptr_q, rptr_q;
    logic [QA:0]   level_q;
    logic          doPush, doPop;

    // Ready depends only on the registered level, so a pop cannot free a slot in the same cycle.
    assign ready_o = (level_q != (QA+1)'(N));
    assign empty_o = (level_q == '0);
    assign doPush  = push_i && ready_o;
    assign doPop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wptr_q <= wptr_q + QA'(1);
            end
            if (doPop) begin
                rptr_q <= rptr_q + QA'(1);
            end
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + (QA+1)'(1);
                2'b01:   level_q <= level_q - (QA+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/accel_issue_queue.sv
// Valid/ready instruction front-end for the master controller: queued entries with
// repeat counts, pipeline-drain barriers and a global hold; NOP whenever nothing issues.
module accel_issue_queue
    import accel_pkg::*;
#(
    parameter int depth    = 3,
    parameter int W        = 16,
    parameter int insWidth = calc_ins_width(depth, W),
    parameter int QA       = 3,
    parameter int RPT_W    = 4,
    parameter int PIPE_LAT = 6
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [insWidth-1:0] in_instr,
    input  logic [RPT_W-1:0]    in_repeat,
    input  logic                in_barrier,
    input  logic                hold,
    output logic [insWidth-1:0] out_instr,
    output logic                out_valid,
    output logic [QA:0]         level,
    output logic                busy
);

    localparam int EW = 1 + RPT_W + insWidth;
    localparam int DW = $clog2(PIPE_LAT + 1);

    logic [EW-1:0]       head;
    logic                empty;
    logic                pop;
    logic                headBarrier;
    logic [RPT_W-1:0]    headRepeat;
    logic [insWidth-1:0] headInstr;

    issue_state_e        state_q, state_d;
    logic [RPT_W-1:0]    rem_q, rem_d;
    logic [insWidth-1:0] cur_q, cur_d;
    logic [insWidth-1:0] out_instr_q, out_instr_d;
    logic                out_valid_q, out_valid_d;
    logic [DW-1:0]       drain_q, drain_d;

    issue_fifo #(
        .QA(QA),
        .EW(EW)
    ) u_fifo (
        .clk_i  (CLK),
        .rst_i  (RST),
        .push_i (in_valid),
        .pop_i  (pop),
        .wdata_i({in_barrier, in_repeat, in_instr}),
        .rdata_o(head),
        .level_o(level),
        .ready_o(in_ready),
        .empty_o(empty)
    );

    assign headBarrier = head[EW-1];
    assign headRepeat  = head[insWidth +: RPT_W];
    assign headInstr   = head[insWidth-1:0];

    // Hold freezes everything but the drain counter and the FIFO push side.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cur_d       = cur_q;
        out_instr_d = insWidth'(INS_NOP);
        out_valid_d = 1'b0;
        pop         = 1'b0;
        if (!hold) begin
            case (state_q)
                IDLE, ISSUE: begin
                    if (state_q == ISSUE && rem_q != '0) begin
                        out_instr_d = cur_q;
                        out_valid_d = 1'b1;
                        rem_d       = rem_q - RPT_W'(1);
                    end else if (!empty) begin
                        if (headBarrier && drain_q != '0) begin
                            state_d = WAIT_DRAIN;
                        end else begin
                            pop         = 1'b1;
                            cur_d       = headInstr;
                            rem_d       = headRepeat;
                            out_instr_d = headInstr;
                            out_valid_d = 1'b1;
                            state_d     = ISSUE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT_DRAIN: begin
                    if (drain_q == '0 && !empty) begin
                        pop         = 1'b1;
                        cur_d       = headInstr;
                        rem_d       = headRepeat;
                        out_instr_d = headInstr;
                        out_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Reloaded on every issuing cycle, so a barrier waits PIPE_LAT+1 edges after the last issue.
    always_comb begin
        if (out_valid_d) begin
            drain_d = DW'(PIPE_LAT);
        end else if (drain_q != '0) begin
            drain_d = drain_q - DW'(1);
        end else begin
            drain_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            cur_q       <= '0;
            out_instr_q <= '0;
            out_valid_q <= 1'b0;
            drain_q     <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            cur_q       <= cur_d;
            out_instr_q <= out_instr_d;
            out_valid_q <= out_valid_d;
            drain_q     <= drain_d;
        end
    end

    assign out_instr = out_instr_q;
    assign out_valid = out_valid_q;
    assign busy      = !empty || (rem_q != '0) || (drain_q != '0);

endmodule

// File: tb/tb_accel_issue_queue.sv
// Scenario bench for accel_issue_queue against a queue-and-arithmetic reference model.
module tb_accel_issue_queue;
    import accel_pkg::*;

    localparam int DEPTH    = 3;
    localparam int WW       = 16;
    localparam int INSW     = calc_ins_width(DEPTH, WW);
    localparam int QA       = 3;
    localparam int RPT_W    = 4;
    localparam int PIPE_LAT = 6;
    localparam int NENT     = 1 << QA;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            inValid, inBarrier, hold;
    logic [RPT_W-1:0] inRepeat;
    logic [INSW-1:0] inInstr;
    logic            inReady, outValid, busy;
    logic [INSW-1:0] outInstr;
    logic [QA:0]     level;

    always #5 CLK = ~CLK;

    accel_issue_queue #(
        .depth(DEPTH), .W(WW), .insWidth(INSW), .QA(QA), .RPT_W(RPT_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .CLK(CLK), .RST(RST), .in_valid(inValid), .in_ready(inReady), .in_instr(inInstr),
        .in_repeat(inRepeat), .in_barrier(inBarrier), .hold(hold), .out_instr(outInstr),
        .out_valid(outValid), .level(level), .busy(busy)
    );

    typedef struct {
        logic            barrier;
        int              rpt;
        logic [INSW-1:0] instr;
    } entry_t;

    // Reference model: queue of entries, copies still owed, and the cycle of the last issue.
    entry_t          mq[$];
    logic [INSW-1:0] curInstr;
    logic [INSW-1:0] expInstr;
    bit              expValid;
    int              copiesLeft;
    int              lastIssue;
    int              cyc = 0;
    int              checks = 0;
    int              failures = 0;

    function automatic bit expBusy();
        return (mq.size() != 0) || (copiesLeft != 0) || ((PIPE_LAT - (cyc - lastIssue)) > 0);
    endfunction

    function automatic logic [INSW-1:0] randInstr();
        logic [INSW-1:0] v;
        v = INSW'($urandom);
        v[0] = 1'b1;
        return v;
    endfunction

    task automatic modelReset();
        mq.delete();
        copiesLeft = 0;
        lastIssue  = cyc - 100;
        expValid   = 1'b0;
        expInstr   = '0;
        curInstr   = '0;
    endtask

    task automatic setIdle();
        inValid = 1'b0; inBarrier = 1'b0; inRepeat = '0; inInstr = '0; hold = 1'b0;
    endtask

    // One clock edge: the model consumes the same inputs the DUT samples, then outputs settle.
    task automatic applyStimulus();
        bit     readyNow;
        entry_t e;
        readyNow  = (mq.size() != NENT);
        e.barrier = inBarrier;
        e.rpt     = int'(inRepeat);
        e.instr   = inInstr;
        cyc++;
        expValid = 1'b0;
        expInstr = '0;
        if (!hold) begin
            if (copiesLeft > 0) begin
                expValid = 1'b1;
                expInstr = curInstr;
                copiesLeft--;
            end else if (mq.size() > 0 && (!mq[0].barrier || (cyc - lastIssue) > PIPE_LAT)) begin
                curInstr   = mq[0].instr;
                copiesLeft = mq[0].rpt;
                void'(mq.pop_front());
                expValid = 1'b1;
                expInstr = curInstr;
            end
        end
        if (expValid) lastIssue = cyc;
        if (inValid && readyNow) mq.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic drainIdle();
        setIdle();
        for (int i = 0; i < 200 && expBusy(); i++) applyStimulus();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("[TB] FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        logic [INSW-1:0] e0;
        setIdle();
        RST = 1'b1;
        modelReset();
        #2;
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b expected 0", outValid); end
        checks++; if (outInstr !== '0) begin failures++; $display("[TB] FAIL rst_instr: got %h expected 0", outInstr); end
        checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready: got %b expected 1", inReady); end
        checks++; if (level !== '0) begin failures++; $display("[TB] FAIL rst_level: got %0d expected 0", level); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        @(negedge CLK);
        RST = 1'b0;
        e0 = randInstr();
        inValid = 1'b1; inInstr = e0; inRepeat = 4'd4;
        applyStimulus();
        inRepeat = '0;
        for (int i = 0; i < 3; i++) begin
            inInstr = randInstr();
            applyStimulus();
        end
        inValid = 1'b0;
        checks++; if (outValid !== 1'b1 || outInstr !== e0) begin
            failures++; $display("[TB] FAIL pre_rst_issue: got %b/%h expected 1/%h", outValid, outInstr, e0);
        end
        checks++; if (level !== 4'd3) begin failures++; $display("[TB] FAIL pre_rst_level: got %0d expected 3", level); end
        #2;
        RST = 1'b1;
        #1;
        modelReset();
        checks++; if (outValid !== 1'b0 || outInstr !== '0) begin
            failures++; $display("[TB] FAIL async_rst_out: got %b/%h expected 0/0", outValid, outInstr);
        end
        checks++; if (level !== '0 || inReady !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL async_rst_state: got level=%0d ready=%b busy=%b expected 0/1/0", level, inReady, busy);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checks++; if (outValid !== 1'b0 || level !== '0) begin
                failures++; $display("[TB] FAIL post_rst_stale: got valid=%b level=%0d expected 0/0", outValid, level);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [INSW-1:0] a, b;
        logic [INSW-1:0] wantI [5];
        bit              wantV [5];
        drainIdle();
        a = randInstr(); b = randInstr();
        wantI = '{a, a, a, b, '0};
        wantV = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        inValid = 1'b1; inInstr = a; inRepeat = 4'd2;
        applyStimulus();
        inInstr = b; inRepeat = 4'd0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            inValid = 1'b0;
            checks++; if (outValid !== wantV[i] || outInstr !== wantI[i]) begin
                failures++; $display("[TB] FAIL b2b_slot%0d: got %b/%h expected %b/%h", i, outValid, outInstr, wantV[i], wantI[i]);
            end
        end
    endtask

    task automatic test_fill_hold();
        logic [INSW-1:0] pushed[$];
        logic [INSW-1:0] issued[$];
        drainIdle();
        hold = 1'b1; inValid = 1'b1;
        for (int i = 0; i < NENT; i++) begin
            inInstr = randInstr(); inRepeat = '0;
            pushed.push_back(inInstr);
            applyStimulus();
            checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL fill_hold_valid: got %b expected 0", outValid); end
        end
        checks++; if (level !== 4'd8 || inReady !== 1'b0) begin
            failures++; $display("[TB] FAIL full_flags: got level=%0d ready=%b expected 8/0", level, inReady);
        end
        inInstr = randInstr();
        applyStimulus();
        checks++; if (level !== 4'd8) begin failures++; $display("[TB] FAIL ninth_push: got level=%0d expected 8", level); end
        setIdle();
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (outValid === 1'b1) issued.push_back(outInstr);
        end
        checks++; if (issued.size() != NENT) begin
            failures++; $display("[TB] FAIL drain_count: got %0d expected %0d", issued.size(), NENT);
        end
        for (int i = 0; i < NENT && i < issued.size(); i++) begin
            checks++; if (issued[i] !== pushed[i]) begin
                failures++; $display("[TB] FAIL drain_order%0d: got %h expected %h", i, issued[i], pushed[i]);
            end
        end
    endtask

    task automatic test_barrier();
        logic [INSW-1:0] a, c;
        int aCyc, cCyc;
        aCyc = -1; cCyc = -1;
        drainIdle();
        a = randInstr(); c = randInstr();
        inValid = 1'b1; inInstr = a; inRepeat = '0; inBarrier = 1'b0;
        applyStimulus();
        inInstr = c; inBarrier = 1'b1;
        for (int i = 0; i < 30 && cCyc < 0; i++) begin
            applyStimulus();
            setIdle();
            if (outValid === 1'b1 && outInstr === a) aCyc = cyc;
            if (outValid === 1'b1 && outInstr === c) cCyc = cyc;
            checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL barrier_busy: got %b expected 1", busy); end
        end
        checks++; if (cCyc < 0 || aCyc < 0 || (cCyc - aCyc) != PIPE_LAT + 1) begin
            failures++; $display("[TB] FAIL barrier_gap: got %0d expected %0d", cCyc - aCyc, PIPE_LAT + 1);
        end
    endtask

    task automatic test_hold_pulse();
        logic [INSW-1:0] a;
        bit wantV [7];
        wantV = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        drainIdle();
        a = randInstr();
        inValid = 1'b1; inInstr = a; inRepeat = 4'd3;
        applyStimulus();
        setIdle();
        for (int i = 0; i < 7; i++) begin
            hold = (i == 2 || i == 3);
            applyStimulus();
            checks++; if (outValid !== wantV[i] || outInstr !== (wantV[i] ? a : '0)) begin
                failures++; $display("[TB] FAIL hold_slot%0d: got %b/%h expected %b", i, outValid, outInstr, wantV[i]);
            end
        end
        hold = 1'b0;
        for (int i = 0; i < PIPE_LAT + 2; i++) begin
            applyStimulus();
            checks++; if (busy !== expBusy()) begin
                failures++; $display("[TB] FAIL hold_busy_tail%0d: got %b expected %b", i, busy, expBusy());
            end
        end
    endtask

    task automatic test_simul_wrap();
        logic [INSW-1:0] pushed[$];
        logic [INSW-1:0] issued[$];
        drainIdle();
        hold = 1'b1; inValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inInstr = randInstr(); pushed.push_back(inInstr);
            applyStimulus();
        end
        hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            inInstr = randInstr(); pushed.push_back(inInstr);
            applyStimulus();
            if (outValid === 1'b1) issued.push_back(outInstr);
            checks++; if (level !== 4'd4) begin failures++; $display("[TB] FAIL simul_level%0d: got %0d expected 4", i, level); end
        end
        setIdle();
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (outValid === 1'b1) issued.push_back(outInstr);
        end
        checks++; if (issued.size() != pushed.size()) begin
            failures++; $display("[TB] FAIL wrap_count: got %0d expected %0d", issued.size(), pushed.size());
        end
        for (int i = 0; i < pushed.size() && i < issued.size(); i++) begin
            checks++; if (issued[i] !== pushed[i]) begin
                failures++; $display("[TB] FAIL wrap_order%0d: got %h expected %h", i, issued[i], pushed[i]);
            end
        end
    endtask

    task automatic test_random();
        drainIdle();
        for (int i = 0; i < 400; i++) begin
            inValid   = ($urandom_range(0, 99) < 55);
            inBarrier = ($urandom_range(0, 99) < 12);
            inRepeat  = RPT_W'($urandom_range(0, 3));
            inInstr   = randInstr();
            hold      = ($urandom_range(0, 99) < 15);
            applyStimulus();
            checks++; if (outValid !== expValid || outInstr !== expInstr) begin
                failures++; $display("[TB] FAIL rand_out@%0d: got %b/%h expected %b/%h", cyc, outValid, outInstr, expValid, expInstr);
            end
            checks++; if (level !== (QA+1)'(mq.size()) || inReady !== (mq.size() != NENT)) begin
                failures++; $display("[TB] FAIL rand_level@%0d: got %0d/%b expected %0d", cyc, level, inReady, mq.size());
            end
            checks++; if (busy !== expBusy()) begin
                failures++; $display("[TB] FAIL rand_busy@%0d: got %b expected %b", cyc, busy, expBusy());
            end
        end
        drainIdle();
    endtask

    initial begin
        setIdle();
        modelReset();
        test_reset();
        test_back_to_back();
        test_fill_hold();
        test_barrier();
        test_hold_pulse();
        test_simul_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accel_issue_queue.md
# accel_issue_queue

Buffered instruction front-end for the accelerator top level. It replaces the free-running raw instruction bus into the master controller with a valid/ready queue. It adds per-entry repeat counts, barrier entries that wait for the datapath pipeline to drain, and a hold input. Its output feeds the master controller's `instruction` port directly, and a zero instruction (NOP) is driven whenever nothing issues.

## Interface
Parameters:
- `depth`, 3: log2 of array dimension D; shared with the accelerator top.
- `W`, 16: datapath word width.
- `insWidth`, 4+2+2*max(2,depth)+max(2^depth,W): instruction width; must match the master controller.
- `QA`, 3: log2 of queue entries (8 entries).
- `RPT_W`, 4: repeat-field width.
- `PIPE_LAT`, 6: cycles from issue until the conv/pool pipeline has retired an instruction.

Ports:
- `CLK`, input, 1: clock, rising edge.
- `RST`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: producer offers an entry.
- `in_ready`, output, 1: queue can accept an entry.
- `in_instr`, input, insWidth: instruction to issue.
- `in_repeat`, input, RPT_W: extra copies; issued count is in_repeat+1.
- `in_barrier`, input, 1: entry waits for pipeline drain before issuing.
- `hold`, input, 1: freezes issue.
- `out_instr`, output, insWidth: to the controller; NOP (all zeros) when not issuing.
- `out_valid`, output, 1: `out_instr` is a real instruction this cycle.
- `level`, output, QA+1: queue occupancy.
- `busy`, output, 1: queue non-empty, copies remaining, or drain counter non-zero.

## Operation
- Queue
  - Circular FIFO, 2^QA entries; each entry holds {barrier, repeat, instr}.
  - Push happens when `in_valid && in_ready`.
  - `in_ready` = (level != 2^QA). It is not raised by a same-cycle pop while full.
  - Pointers wrap modulo 2^QA.
  - `level` updates on push and pop; a simultaneous push and pop leaves it unchanged.
- Issue FSM states:
  - IDLE: nothing loaded.
  - ISSUE: loaded entry emitting copies; `rem` counts copies still to emit after the current one.
  - WAIT_DRAIN: head entry is a barrier and `drain_cnt` != 0.
- Head acceptance:
  - Applies in IDLE, or in ISSUE with `rem`==0, when the queue is non-empty and `hold`=0.
  - Barrier head with `drain_cnt`!=0: go to WAIT_DRAIN, no pop.
  - Otherwise: pop; load `out_instr`; `out_valid`=1; `rem`=repeat; go to ISSUE.
- ISSUE with `rem`>0 and `hold`=0: re-emit the same instruction; `rem` decrements.
- ISSUE with `rem`==0 and no acceptable head: drive NOP, `out_valid`=0, go to IDLE.
- WAIT_DRAIN: NOP output. When `drain_cnt` reaches 0 and `hold`=0, pop and issue the barrier entry.
- Drain counter:
  - Loads PIPE_LAT on every cycle with `out_valid`=1.
  - Otherwise decrements to 0 and saturates there.
  - Keeps counting during `hold`.
- `hold`=1: next cycle drives NOP with `out_valid`=0. State, `rem`, head entry and queue are unchanged; pushes are still accepted.
- Reset (asynchronous, any state): queue emptied; pointers, `level`, `rem`, `drain_cnt` = 0; FSM = IDLE.

## Timing
- Reset values: `out_instr`=0, `out_valid`=0, `in_ready`=1, `level`=0, `busy`=0.
- All outputs are registered except `in_ready` and `busy`, which are decoded from registers.
- Latency: an entry pushed at edge k into an empty queue, with hold=0 and no barrier, appears on `out_instr` after edge k+1.
- Back-to-back entries issue with no bubble: the next pop happens on the same edge the last copy of the previous entry retires.
- Barrier entry: issues no earlier than PIPE_LAT+1 edges after the last valid issue.
- `hold` rise at edge h: `out_valid`=0 from edge h. Release at edge r: issue resumes at edge r+1.
- `busy` falls the cycle `drain_cnt` reaches 0 with the queue empty and `rem`=0.

## Structure
- Shared package `accel_pkg`:
  - `INS_NOP` constant.
  - insWidth computation function.
  - FSM state enumeration {IDLE, ISSUE, WAIT_DRAIN}.
- Sub-module `issue_fifo`, parametrised by QA and entry width. It owns the storage, pointers, `level` and `in_ready`.
- The FSM, repeat counter and drain counter live in `accel_issue_queue`.

## Test plan
- Reset mid-ISSUE with 3 queued entries and `rem`=2: outputs return to reset values immediately; `level`=0 after release; no stale issue follows.
- Push A (repeat=2) then B (repeat=0) on consecutive cycles: `out_instr` = A,A,A,B on four consecutive cycles, then NOP with `out_valid`=0.
- Fill 8 entries with `hold`=1: `in_ready`=0 at `level`=8; a 9th offer is not accepted; releasing `hold` drains all 8 in order.
- Barrier test, PIPE_LAT=6:
  - Push A (repeat=0) then barrier entry C.
  - C issues exactly 7 edges after A issues.
  - `busy` stays high throughout.
- `hold` pulsed for 2 cycles in the middle of A (repeat=3): four A copies total, with a 2-cycle NOP gap; `drain_cnt` keeps decrementing during the gap.
- Simultaneous push and pop at `level`=4: `level` stays 4; wrap-around after 20 push/pop pairs preserves FIFO order.
